// File: rtl/rf_pkg.sv
// Shared defaults and select-width sizing for the bypassing register file.
package rf_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_SEL_W    = clog2(DEF_NUM_REGS);

endpackage

// File: rtl/rf_bypass_rdport.sv
// One read port: select mux with same-cycle write bypass, range check and
// optional output register.
module rf_bypass_rdport
  import rf_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int SEL_W    = DEF_SEL_W,
  parameter int READ_REG = 0,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [SEL_W-1:0]           rd_sel,
  input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
  input  logic [SEL_W-1:0]           wr_sel,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       wr_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_ill
);
  localparam logic [SEL_W:0] NREGS = (SEL_W+1)'(NUM_REGS);

  logic [DATA_W-1:0] data_d;

  assign rd_ill = ({1'b0, rd_sel} >= NREGS);

  // wr_en arrives already qualified by range and reset, so a hit is a real write.
  always_comb begin
    data_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_sel == SEL_W'(i)) data_d = regs_flat[i*DATA_W +: DATA_W];
    end
    if (BYPASS && wr_en && (wr_sel == rd_sel)) data_d = wr_data;
  end

  if (READ_REG != 0) begin : g_reg
    logic [DATA_W-1:0] data_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) data_q <= '0;
      else      data_q <= data_d;
    end
    assign rd_data = data_q;
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign rd_data = data_d;
  end

endmodule

// File: rtl/rf_bypass_param.sv
// Parametrised register file: storage, single write port, sticky range
// error and a generated bank of bypassing read ports.
module rf_bypass_param
  import rf_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                NUM_REGS  = DEF_NUM_REGS,
  parameter int                SEL_W     = clog2(NUM_REGS),
  parameter int                NUM_RD    = 2,
  parameter int                READ_REG  = 0,
  parameter logic [NUM_RD-1:0] BYPASS_EN = '1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*SEL_W-1:0]  rd_sel,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [SEL_W-1:0]         wr_sel,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     wr_en,
  output logic                     err
);
  localparam logic [SEL_W:0] NREGS = (SEL_W+1)'(NUM_REGS);

  logic [DATA_W-1:0]          regs_q [NUM_REGS];
  logic [NUM_REGS*DATA_W-1:0] regs_flat;
  logic                       wr_in_rng;
  logic                       wr_ok;
  logic [NUM_RD-1:0]          rd_ill;
  logic                       err_d;
  logic                       err_q;

  assign wr_in_rng = ({1'b0, wr_sel} < NREGS);
  // Gating with rst keeps the bypass from leaking wr_data while the array is held clear.
  assign wr_ok     = wr_en && wr_in_rng && rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_sel == SEL_W'(i)) regs_q[i] <= wr_data;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    rf_bypass_rdport #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .SEL_W    (SEL_W),
      .READ_REG (READ_REG),
      .BYPASS   (BYPASS_EN[p])
    ) u_port (
      .clk       (clk),
      .rst       (rst),
      .rd_sel    (rd_sel[p*SEL_W +: SEL_W]),
      .regs_flat (regs_flat),
      .wr_sel    (wr_sel),
      .wr_data   (wr_data),
      .wr_en     (wr_ok),
      .rd_data   (rd_data[p*DATA_W +: DATA_W]),
      .rd_ill    (rd_ill[p])
    );
  end

  // Sticky: only reset clears it.
  assign err_d = err_q | (wr_en & ~wr_in_rng) | (|rd_ill);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign err = err_q;

endmodule

// File: tb/tb_rf_bypass_param.sv
// Bench for rf_bypass_param: three configurations (default combinational,
// registered 6-entry with port-1 bypass off, wide 4-port) against a behavioural model.
module tb_rf_bypass_param;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [5:0]   a_rd_sel;  logic [31:0]  a_rd_data;
  logic [2:0]   a_wr_sel;  logic [15:0]  a_wr_data;  logic a_wr_en;  logic a_err;
  logic [5:0]   b_rd_sel;  logic [31:0]  b_rd_data;
  logic [2:0]   b_wr_sel;  logic [15:0]  b_wr_data;  logic b_wr_en;  logic b_err;
  logic [15:0]  c_rd_sel;  logic [127:0] c_rd_data;
  logic [3:0]   c_wr_sel;  logic [31:0]  c_wr_data;  logic c_wr_en;  logic c_err;

  rf_bypass_param u_a (
    .clk(clk), .rst(rst), .rd_sel(a_rd_sel), .rd_data(a_rd_data),
    .wr_sel(a_wr_sel), .wr_data(a_wr_data), .wr_en(a_wr_en), .err(a_err)
  );

  rf_bypass_param #(
    .DATA_W(16), .NUM_REGS(6), .SEL_W(3), .NUM_RD(2), .READ_REG(1), .BYPASS_EN(2'b01)
  ) u_b (
    .clk(clk), .rst(rst), .rd_sel(b_rd_sel), .rd_data(b_rd_data),
    .wr_sel(b_wr_sel), .wr_data(b_wr_data), .wr_en(b_wr_en), .err(b_err)
  );

  rf_bypass_param #(
    .DATA_W(32), .NUM_REGS(16), .SEL_W(4), .NUM_RD(4), .READ_REG(0), .BYPASS_EN(4'b1111)
  ) u_c (
    .clk(clk), .rst(rst), .rd_sel(c_rd_sel), .rd_data(c_rd_data),
    .wr_sel(c_wr_sel), .wr_data(c_wr_data), .wr_en(c_wr_en), .err(c_err)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic chk_on;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] ma [8];
  logic [15:0] mb [6];
  logic [15:0] qb [2];
  logic        eb;
  logic [31:0] mc [16];

  function automatic logic [15:0] raw_a(input int p);
    logic [2:0] s;
    s = a_rd_sel[p*3 +: 3];
    if (rst && a_wr_en && a_wr_sel == s) return a_wr_data;
    return ma[s];
  endfunction

  function automatic logic [15:0] raw_b(input int p);
    logic [2:0] s;
    s = b_rd_sel[p*3 +: 3];
    if (s >= 3'd6) return 16'h0000;
    if (p == 0 && rst && b_wr_en && b_wr_sel == s) return b_wr_data;
    return mb[s];
  endfunction

  function automatic logic [31:0] raw_c(input int p);
    logic [3:0] s;
    s = c_rd_sel[p*4 +: 4];
    if (rst && c_wr_en && c_wr_sel == s) return c_wr_data;
    return mc[s];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++)  ma[i] <= '0;
      for (int i = 0; i < 6; i++)  mb[i] <= '0;
      for (int i = 0; i < 16; i++) mc[i] <= '0;
      qb[0] <= '0;
      qb[1] <= '0;
      eb    <= 1'b0;
    end else begin
      if (a_wr_en) ma[a_wr_sel] <= a_wr_data;
      if (b_wr_en) begin
        if (b_wr_sel < 3'd6) mb[b_wr_sel] <= b_wr_data;
        else                 eb <= 1'b1;
      end
      for (int p = 0; p < 2; p++) begin
        if (b_rd_sel[p*3 +: 3] >= 3'd6) eb <= 1'b1;
        qb[p] <= raw_b(p);
      end
      if (c_wr_en) mc[c_wr_sel] <= c_wr_data;
    end
  end

  // Compare process: every negedge while checking is enabled.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int p = 0; p < 2; p++) begin
        check("cmp_a_rd", {16'h0, a_rd_data[p*16 +: 16]}, {16'h0, raw_a(p)});
        check("cmp_b_rd", {16'h0, b_rd_data[p*16 +: 16]}, {16'h0, qb[p]});
      end
      for (int p = 0; p < 4; p++) begin
        check("cmp_c_rd", c_rd_data[p*32 +: 32], raw_c(p));
      end
      check("cmp_a_err", {31'h0, a_err}, 32'h0);
      check("cmp_b_err", {31'h0, b_err}, {31'h0, eb});
      check("cmp_c_err", {31'h0, c_err}, 32'h0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    a_rd_sel = '0; a_wr_sel = '0; a_wr_data = '0; a_wr_en = 1'b0;
    b_rd_sel = '0; b_wr_sel = '0; b_wr_data = '0; b_wr_en = 1'b0;
    c_rd_sel = '0; c_wr_sel = '0; c_wr_data = '0; c_wr_en = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst    = 1'b1;
    chk_on = 1'b0;
    idle_all();
    #2 rst = 1'b0;
    #1 chk_on = 1'b1;
    repeat (2) tick();
    check("reset_a_rd", a_rd_data, 32'h0);
    check("reset_b_rd", b_rd_data, 32'h0);
    check("reset_b_err", {31'h0, b_err}, 32'h0);
    @(negedge clk);
    #2 rst = 1'b1;

    // Reset state visible through every select.
    for (int s = 0; s < 8; s++) begin
      tick();
      a_rd_sel = {3'(7 - s), 3'(s)};
      #2 check("t1_rd_zero", a_rd_data, 32'h0);
    end
    check("t1_err", {31'h0, a_err}, 32'h0);

    // Write then read, then same-cycle bypass.
    tick();
    a_wr_en = 1'b1; a_wr_sel = 3'd3; a_wr_data = 16'hBEEF; a_rd_sel = '0;
    tick();
    a_wr_en = 1'b0; a_rd_sel = {3'd0, 3'd3};
    #1 check("t2_rd_old", {16'h0, a_rd_data[15:0]}, 32'h0000BEEF);
    a_wr_en = 1'b1; a_wr_data = 16'h1234; a_rd_sel = {3'd3, 3'd3};
    #1 check("t2_byp_p1", {16'h0, a_rd_data[31:16]}, 32'h00001234);
    check("t2_byp_p0", {16'h0, a_rd_data[15:0]}, 32'h00001234);
    tick();
    a_wr_en = 1'b0;
    #2 check("t2_stored", {16'h0, a_rd_data[15:0]}, 32'h00001234);

    // Fill A and sweep reads (model-checked each cycle).
    for (int i = 0; i < 8; i++) begin
      tick();
      a_wr_en = 1'b1; a_wr_sel = 3'(i); a_wr_data = 16'h1000 + 16'(i * 16'h0111);
      a_rd_sel = {3'(i), 3'(7 - i)};
    end
    tick();
    a_wr_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      a_rd_sel = {3'(i + 3), 3'(i)};
    end
    a_rd_sel = {3'd0, 3'd6};
    #2 check("t2_fill_r6", {16'h0, a_rd_data[15:0]}, 32'h00001666);

    // Registered read, port-1 bypass disabled.
    tick();
    b_wr_en = 1'b1; b_wr_sel = 3'd5; b_wr_data = 16'h00AA;
    tick();
    b_wr_data = 16'h5555; b_rd_sel = {3'd5, 3'd5};
    tick();
    b_wr_en = 1'b0;
    #2 check("t3_p0_byp", {16'h0, b_rd_data[15:0]}, 32'h00005555);
    check("t3_p1_old", {16'h0, b_rd_data[31:16]}, 32'h000000AA);
    tick();
    #2 check("t3_p1_new", {16'h0, b_rd_data[31:16]}, 32'h00005555);

    // Illegal read select.
    tick();
    b_rd_sel = {3'd0, 3'd7};
    #2 check("t4_err_pre", {31'h0, b_err}, 32'h0);
    tick();
    b_rd_sel = {3'd1, 3'd0};
    #2 check("t4_ill_zero", {16'h0, b_rd_data[15:0]}, 32'h0);
    check("t4_err_set", {31'h0, b_err}, 32'h1);
    for (int s = 0; s < 4; s++) begin
      tick();
      b_rd_sel = {3'(s + 1), 3'(s)};
    end
    tick();
    b_wr_en = 1'b1; b_wr_sel = 3'd6; b_wr_data = 16'hDEAD;
    tick();
    b_wr_en = 1'b0;
    for (int s = 0; s < 6; s++) begin
      tick();
      b_rd_sel = {3'(s), 3'(s)};
    end
    tick();
    #2 check("t4_r5_kept", {16'h0, b_rd_data[15:0]}, 32'h00005555);
    check("t4_err_sticky", {31'h0, b_err}, 32'h1);

    // Reset in the middle of a write.
    tick();
    a_wr_en = 1'b1; a_wr_sel = 3'd2; a_wr_data = 16'hFFFF;
    b_wr_en = 1'b1; b_wr_sel = 3'd2; b_wr_data = 16'hFFFF;
    c_wr_en = 1'b1; c_wr_sel = 4'd2; c_wr_data = 32'hFFFFFFFF;
    #7 rst = 1'b0;
    @(negedge clk);
    idle_all();
    #2 rst = 1'b1;
    tick();
    a_rd_sel = {3'd2, 3'd2}; b_rd_sel = {3'd2, 3'd2}; c_rd_sel = {4{4'd2}};
    #2 check("t5_a_r2", {16'h0, a_rd_data[15:0]}, 32'h0);
    check("t5_c_r2", c_rd_data[31:0], 32'h0);
    check("t5_err_clr", {31'h0, b_err}, 32'h0);
    tick();
    #2 check("t5_b_r2", {16'h0, b_rd_data[15:0]}, 32'h0);

    // Illegal write alone raises err.
    b_wr_en = 1'b1; b_wr_sel = 3'd6; b_wr_data = 16'h7777;
    tick();
    b_wr_en = 1'b0;
    #2 check("t5_wr_ill_err", {31'h0, b_err}, 32'h1);

    // Wide configuration.
    for (int i = 0; i < 16; i++) begin
      tick();
      c_wr_en = 1'b1; c_wr_sel = 4'(i); c_wr_data = 32'hA5A50000 + 32'(i);
      c_rd_sel = {4'(i + 1), 4'(i), 4'(15 - i), 4'(i + 8)};
    end
    tick();
    c_wr_en = 1'b0;
    for (int r = 0; r < 16; r++) begin
      c_rd_sel = {4'(r + 12), 4'(r + 8), 4'(r + 4), 4'(r)};
      #2;
      for (int p = 0; p < 4; p++) begin
        check("t6_rot", c_rd_data[p*32 +: 32], 32'hA5A50000 + 32'((r + 4 * p) % 16));
      end
      tick();
    end
    c_wr_en = 1'b1; c_wr_sel = 4'd9; c_wr_data = 32'hCAFEF00D; c_rd_sel = {4{4'd9}};
    #2;
    for (int p = 0; p < 4; p++) begin
      check("t6_byp_all", c_rd_data[p*32 +: 32], 32'hCAFEF00D);
    end
    tick();
    c_wr_en = 1'b0; c_rd_sel = {4'd9, 4'd9, 4'd8, 4'd9};
    #2 check("t6_after_p0", c_rd_data[31:0], 32'hCAFEF00D);
    check("t6_after_p1", c_rd_data[63:32], 32'hA5A50008);

    tick();
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
